// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for seq_magnitude_comparator: FSM states, result encodings
// and cascade resolution.
package seq_magnitude_comparator_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Results are packed as {lt, eq, gt}
    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    // gt_in wins over lt_in, which wins over eq_in; no cascade input at all means equal
    function automatic logic [2:0] resolve_cascade(input logic lt_c, input logic eq_c,
                                                   input logic gt_c);
        logic [2:0] res;
        casez ({gt_c, lt_c, eq_c})
            3'b1??:  res = RES_GT;
            3'b01?:  res = RES_LT;
            default: res = RES_EQ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// Combinational magnitude compare of one W-bit slice.
module chunk_compare #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         x_gt_y,
    output logic         x_lt_y
);

    assign x_gt_y = (x > y);
    assign x_lt_y = (x < y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Sequential MSB-first magnitude comparator with early exit and cascade inputs.
// Define SIGNED_CMP_EN for two's-complement operands (sign bit flipped on the MSB slice).
module seq_magnitude_comparator
    import seq_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             lt_in,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             out_valid
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        casc_q, casc_d;
    logic [2:0]        res_q, res_d;
    logic              out_valid_q, out_valid_d;

    logic [CHUNK-1:0]  slice_a, slice_b;
    logic              slice_gt, slice_lt;

    always_comb begin
        slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
        slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
`ifdef SIGNED_CMP_EN
        // Flipping the sign bit maps two's complement order onto unsigned order
        if (idx_q == LAST_IDX) begin
            slice_a[CHUNK-1] = ~slice_a[CHUNK-1];
            slice_b[CHUNK-1] = ~slice_b[CHUNK-1];
        end
`endif
    end

    chunk_compare #(
        .W (CHUNK)
    ) u_chunk_compare (
        .x      (slice_a),
        .y      (slice_b),
        .x_gt_y (slice_gt),
        .x_lt_y (slice_lt)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        casc_d      = casc_q;
        res_d       = res_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    casc_d  = {lt_in, eq_in, gt_in};
                    idx_d   = LAST_IDX;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (slice_gt) begin
                    res_d       = RES_GT;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (slice_lt) begin
                    res_d       = RES_LT;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (idx_q == '0) begin
                    res_d       = resolve_cascade(casc_q[2], casc_q[1], casc_q[0]);
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= LAST_IDX;
            a_q         <= '0;
            b_q         <= '0;
            casc_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            casc_q      <= casc_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign lt        = res_q[2];
    assign eq        = res_q[1];
    assign gt        = res_q[0];
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4); honours SIGNED_CMP_EN.
module tb_seq_magnitude_comparator;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] a, b;
    logic             lt_in, eq_in, gt_in;
    logic             lt, eq, gt;
    logic             out_valid;

    int testsRun    = 0;
    int testsFailed = 0;

    seq_magnitude_comparator #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .a         (a),
        .b         (b),
        .lt_in     (lt_in),
        .eq_in     (eq_in),
        .gt_in     (gt_in),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: whole-operand compare, latency = slices scanned down to the first difference
    function automatic void modelCompare(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                         input logic [2:0] mcasc, output logic [2:0] res,
                                         output int lat);
        logic [WIDTH-1:0] diff;
        diff = ma ^ mb;
        lat  = NCHUNK;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (((diff >> (i * CHUNK)) & ((1 << CHUNK) - 1)) != 0) begin
                lat = NCHUNK - i;
                break;
            end
        end
`ifdef SIGNED_CMP_EN
        if ($signed(ma) > $signed(mb))      res = 3'b001;
        else if ($signed(ma) < $signed(mb)) res = 3'b100;
`else
        if (ma > mb)      res = 3'b001;
        else if (ma < mb) res = 3'b100;
`endif
        else if (mcasc[0]) res = 3'b001;
        else if (mcasc[2]) res = 3'b100;
        else               res = 3'b010;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one compare starting just after a clock edge with the DUT idle.
    // casc is {lt_in, eq_in, gt_in}; hold keeps start high for back-to-back operation.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] ta,
                                 input logic [WIDTH-1:0] tb, input logic [2:0] casc,
                                 input bit hold);
        logic [2:0] expRes;
        int         expLat;
        int         lat;
        modelCompare(ta, tb, casc, expRes, expLat);
        a = ta;
        b = tb;
        {lt_in, eq_in, gt_in} = casc;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, ":ready_busy"}, 32'(ready), 32'd0);
        if (!hold) start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        {lt_in, eq_in, gt_in} = 3'($urandom);
        lat = 0;
        while (lat < NCHUNK + 2) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        checkOutput({tag, ":latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ":result"}, 32'({lt, eq, gt}), 32'(expRes));
        if (!hold) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ":pulse"}, 32'(out_valid), 32'd0);
            checkOutput({tag, ":held"}, 32'({lt, eq, gt}), 32'(expRes));
            checkOutput({tag, ":ready_idle"}, 32'(ready), 32'd1);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        {lt_in, eq_in, gt_in} = 3'b000;
        #2;
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_result", 32'({lt, eq, gt}), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("t1_equal", 16'h1234, 16'h1234, 3'b010, 1'b0);
        applyStimulus("t2_early_gt", 16'h2000, 16'h1FFF, 3'b000, 1'b0);
        applyStimulus("t2_late_lt", 16'h1230, 16'h1231, 3'b000, 1'b0);
        applyStimulus("t3_casc_lt", 16'h00AA, 16'h00AA, 3'b100, 1'b0);
        applyStimulus("t3_casc_gt", 16'h00AA, 16'h00AA, 3'b101, 1'b0);
        applyStimulus("t3_casc_none", 16'h00AA, 16'h00AA, 3'b000, 1'b0);
        applyStimulus("t4_sign", 16'hFFFF, 16'h0001, 3'b000, 1'b0);

        // Reset in the second BUSY cycle of a full-length compare
        a = 16'h5555;
        b = 16'h5555;
        {lt_in, eq_in, gt_in} = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_ready", 32'(ready), 32'd1);
        checkOutput("t5_rst_result", 32'({lt, eq, gt}), 32'd0);
        checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_no_stale_valid", 32'(out_valid), 32'd0);
        applyStimulus("t5_after_rst", 16'h0F00, 16'h0F01, 3'b001, 1'b0);

        // Back-to-back with start held; operands change while BUSY must be ignored
        for (int i = 0; i < 8; i++) begin
            ra = WIDTH'($urandom);
            case (i % 3)
                0: rb = ra;
                1: rb = ra ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
                default: rb = WIDTH'($urandom);
            endcase
            applyStimulus($sformatf("t6_b2b%0d", i), ra, rb, 3'($urandom), 1'b1);
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            case (i % 4)
                0: rb = ra;
                1: rb = ra ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
                2: rb = ra ^ (WIDTH'(1) << $urandom_range(CHUNK - 1, 0));
                default: rb = WIDTH'($urandom);
            endcase
            applyStimulus($sformatf("rand%0d", i), ra, rb, 3'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
